// File: rtl/ppu_spr_fetch_if.sv
// Bus bundle for the sprite fetch engine.
// Groups the start/config inputs, the secondary-OAM read port, the VRAM
// pattern read port and the per-sprite pipeline load outputs.
//   master : the fetch engine (drives o_*, samples i_*)
//   slave  : the environment (secondary OAM, VRAM arbiter, sprite pipelines)
interface ppu_spr_fetch_if;
  logic        i_start;
  logic [7:0]  i_scanline;
  logic [3:0]  i_spr_cnt;
  logic        i_spr_size;
  logic        i_spr_pt_sel;
  logic [4:0]  o_soam_addr;
  logic [7:0]  i_soam_data;
  logic        o_vram_req;
  logic [13:0] o_vram_addr;
  logic        i_vram_ack;
  logic [7:0]  i_vram_data;
  logic [7:0]  o_xcnt;
  logic [7:0]  o_xcnt_wr;
  logic [7:0]  o_attr;
  logic [7:0]  o_attr_we;
  logic [15:0] o_patt;
  logic [7:0]  o_patt_we;
  logic        o_busy;
  logic        o_done;

  modport master (
    input  i_start, i_scanline, i_spr_cnt, i_spr_size, i_spr_pt_sel,
    input  i_soam_data, i_vram_ack, i_vram_data,
    output o_soam_addr, o_vram_req, o_vram_addr,
    output o_xcnt, o_xcnt_wr, o_attr, o_attr_we, o_patt, o_patt_we,
    output o_busy, o_done
  );

  modport slave (
    output i_start, i_scanline, i_spr_cnt, i_spr_size, i_spr_pt_sel,
    output i_soam_data, i_vram_ack, i_vram_data,
    input  o_soam_addr, o_vram_req, o_vram_addr,
    input  o_xcnt, o_xcnt_wr, o_attr, o_attr_we, o_patt, o_patt_we,
    input  o_busy, o_done
  );
endinterface

// File: rtl/ppu_spr_fetch.sv
// Sprite fetch engine for the horizontal-blank window.
// Walks the 8 secondary-OAM slots, reads Y/tile/attr/X, computes the pattern
// row address (V-flip, 8x16 aware), fetches both bit planes over the VRAM
// port and loads the 8 sprite pipelines. Unused slots get a transparent
// sprite parked at X=0xFF.
// Ports:
//   i_clk  : PPU clock
//   i_rstn : asynchronous active-low reset
//   bus    : ppu_spr_fetch_if.master (config, SOAM port, VRAM port, loads)
module ppu_spr_fetch (
  input  logic           i_clk,
  input  logic           i_rstn,
  ppu_spr_fetch_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_Y, S_RD_TILE, S_RD_ATTR, S_RD_X, S_WR_X,
    S_FETCH_LO, S_FETCH_HI, S_WR_PATT, S_EMPTY, S_DONE
  } state_t;

  state_t      state, state_next;
  logic [2:0]  slot;
  logic [3:0]  cnt;
  logic        size;
  logic        pt_sel;
  logic [7:0]  y, tile, attr, patt_lo, patt_hi;
  logic        vram_req;
  logic [13:0] vram_addr;

  logic [7:0]  slot_oh;
  logic [3:0]  slot_inc;
  logic [7:0]  diff;
  logic [3:0]  row;
  logic [13:0] addr_lo, addr_hi;
  state_t      after_slot;

  assign slot_oh  = 8'd1 << slot;
  assign slot_inc = {1'b0, slot} + 4'd1;

  // Row within the sprite; V-flip mirrors over 8 or 16 lines.
  always_comb begin
    diff = bus.i_scanline - y;
    row  = diff[3:0];
    if (attr[7]) begin
      if (size) row = 4'd15 - diff[3:0];
      else      row = {1'b0, 3'd7 - diff[2:0]};
    end
    if (size) begin
      addr_lo = {1'b0, tile[0], tile[7:1], row[3], 1'b0, row[2:0]};
      addr_hi = {1'b0, tile[0], tile[7:1], row[3], 1'b1, row[2:0]};
    end else begin
      addr_lo = {1'b0, pt_sel, tile, 1'b0, row[2:0]};
      addr_hi = {1'b0, pt_sel, tile, 1'b1, row[2:0]};
    end
  end

  // Where to go once the current slot has been written.
  always_comb begin
    if (slot == 3'd7)     after_slot = S_DONE;
    else if (slot_inc < cnt) after_slot = S_RD_Y;
    else                  after_slot = S_EMPTY;
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (bus.i_start)
                state_next = (bus.i_spr_cnt != 4'd0) ? S_RD_Y : S_EMPTY;
      S_RD_Y:     state_next = S_RD_TILE;
      S_RD_TILE:  state_next = S_RD_ATTR;
      S_RD_ATTR:  state_next = S_RD_X;
      S_RD_X:     state_next = S_WR_X;
      S_WR_X:     state_next = S_FETCH_LO;
      S_FETCH_LO: if (bus.i_vram_ack) state_next = S_FETCH_HI;
      S_FETCH_HI: if (bus.i_vram_ack) state_next = S_WR_PATT;
      S_WR_PATT:  state_next = after_slot;
      S_EMPTY:    state_next = after_slot;
      S_DONE:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Output logic. The attribute is strobed in RD_X, ahead of the pattern,
  // so the pipeline already holds the X-mirror bit at pattern-write time.
  always_comb begin
    bus.o_soam_addr = 5'd0;
    bus.o_xcnt      = 8'd0;
    bus.o_xcnt_wr   = 8'd0;
    bus.o_attr      = 8'd0;
    bus.o_attr_we   = 8'd0;
    bus.o_patt      = 16'd0;
    bus.o_patt_we   = 8'd0;
    bus.o_done      = 1'b0;
    bus.o_busy      = (state != S_IDLE);
    case (state)
      S_RD_Y:    bus.o_soam_addr = {slot, 2'd0};
      S_RD_TILE: bus.o_soam_addr = {slot, 2'd1};
      S_RD_ATTR: bus.o_soam_addr = {slot, 2'd2};
      S_RD_X: begin
        bus.o_soam_addr = {slot, 2'd3};
        bus.o_attr      = bus.i_soam_data;
        bus.o_attr_we   = slot_oh;
      end
      S_WR_X: begin
        bus.o_xcnt    = bus.i_soam_data;
        bus.o_xcnt_wr = slot_oh;
      end
      S_WR_PATT: begin
        bus.o_patt    = {patt_hi, patt_lo};
        bus.o_patt_we = slot_oh;
      end
      S_EMPTY: begin
        bus.o_xcnt    = 8'hFF;
        bus.o_xcnt_wr = slot_oh;
        bus.o_attr_we = slot_oh;
        bus.o_patt_we = slot_oh;
      end
      S_DONE:  bus.o_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.o_vram_req  = vram_req;
  assign bus.o_vram_addr = vram_addr;

  // Datapath registers. The VRAM request/address are loaded one cycle ahead
  // (in WR_X) so a same-cycle ack can complete FETCH_LO in a single cycle.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      slot      <= 3'd0;
      cnt       <= 4'd0;
      size      <= 1'b0;
      pt_sel    <= 1'b0;
      y         <= 8'd0;
      tile      <= 8'd0;
      attr      <= 8'd0;
      patt_lo   <= 8'd0;
      patt_hi   <= 8'd0;
      vram_req  <= 1'b0;
      vram_addr <= 14'd0;
    end else begin
      case (state)
        S_IDLE: if (bus.i_start) begin
          slot   <= 3'd0;
          cnt    <= (bus.i_spr_cnt > 4'd8) ? 4'd8 : bus.i_spr_cnt;
          size   <= bus.i_spr_size;
          pt_sel <= bus.i_spr_pt_sel;
        end
        S_RD_TILE: y    <= bus.i_soam_data;
        S_RD_ATTR: tile <= bus.i_soam_data;
        S_RD_X:    attr <= bus.i_soam_data;
        S_WR_X: begin
          vram_req  <= 1'b1;
          vram_addr <= addr_lo;
        end
        S_FETCH_LO: if (bus.i_vram_ack) begin
          patt_lo   <= bus.i_vram_data;
          vram_addr <= addr_hi;
        end
        S_FETCH_HI: if (bus.i_vram_ack) begin
          patt_hi  <= bus.i_vram_data;
          vram_req <= 1'b0;
        end
        S_WR_PATT, S_EMPTY: slot <= slot + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_spr_fetch.sv
module tb_ppu_spr_fetch;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ppu_spr_fetch_if ifc();
  ppu_spr_fetch dut (.i_clk(clk), .i_rstn(rstn), .bus(ifc.master));

  typedef struct {
    int          kind;   // 0 strobe, 1 vram fetch, 2 done
    logic [23:0] strb;   // {attr_we, xcnt_wr, patt_we}
    logic [31:0] val;
  } ev_t;

  ev_t        q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         t1 = 0;
  int         waits_total = 0;
  int         wait_mode = 0;   // <0 : random 0..3 per fetch
  int         cur_wait = 0;
  int         wcnt = 0;
  int         fetch_seen = 0;
  logic [7:0] soam [32];
  logic [7:0] vmem [16384];
  logic       prev_req = 1'b0, prev_ack = 1'b0;
  logic [13:0] prev_addr = 14'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Secondary OAM: one-cycle registered read.
  always @(posedge clk) ifc.i_soam_data <= soam[ifc.o_soam_addr];

  function automatic int pick_wait();
    if (wait_mode < 0) return int'($urandom_range(0, 3));
    return wait_mode;
  endfunction

  // VRAM responder, updated shortly after the clock edge.
  always @(posedge clk) begin
    #1;
    if (rstn && prev_req && !prev_ack && ifc.o_vram_req) begin
      checks++;
      if (ifc.o_vram_addr !== prev_addr) begin
        errors++;
        $display("FAIL addr_stable got %h want %h", ifc.o_vram_addr, prev_addr);
      end
    end
    if (rstn && ifc.o_vram_req) begin
      if (wcnt >= cur_wait) begin
        ifc.i_vram_ack  = 1'b1;
        ifc.i_vram_data = vmem[ifc.o_vram_addr];
        wcnt = 0;
        cur_wait = pick_wait();
      end else begin
        ifc.i_vram_ack  = 1'b0;
        ifc.i_vram_data = 8'($urandom);
        wcnt++;
        waits_total++;
      end
    end else begin
      ifc.i_vram_ack = 1'b0;
      wcnt = 0;
    end
    prev_req  = ifc.o_vram_req;
    prev_ack  = ifc.i_vram_ack;
    prev_addr = ifc.o_vram_addr;
  end

  task automatic pop_cmp(input int kind, input logic [23:0] strb,
                         input logic [31:0] val, input string nm);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected event got strb=%h val=%h want none", nm, strb, val);
      return;
    end
    e = q.pop_front();
    if (e.kind != kind || e.strb !== strb || e.val !== val) begin
      errors++;
      $display("FAIL %s got kind=%0d strb=%h val=%h want kind=%0d strb=%h val=%h",
               nm, kind, strb, val, e.kind, e.strb, e.val);
    end
  endtask

  // Monitor: every observable output event is matched against the queue.
  always @(negedge clk) begin
    logic [23:0] s;
    logic [31:0] v;
    s = {ifc.o_attr_we, ifc.o_xcnt_wr, ifc.o_patt_we};
    if (s != 24'd0) begin
      v = {(ifc.o_attr_we != 0) ? ifc.o_attr : 8'd0,
           (ifc.o_xcnt_wr != 0) ? ifc.o_xcnt : 8'd0,
           (ifc.o_patt_we != 0) ? ifc.o_patt : 16'd0};
      pop_cmp(0, s, v, "strobe");
    end
    if (ifc.o_vram_req === 1'b1 && ifc.i_vram_ack === 1'b1) begin
      fetch_seen++;
      pop_cmp(1, 24'd0, {18'd0, ifc.o_vram_addr}, "fetch");
    end
    if (ifc.o_done === 1'b1)
      pop_cmp(2, 24'd0, 32'(cyc - t1 + 1 - waits_total), "done_cycle");
    $display("cyc %0d strb=%h req=%b ack=%b addr=%h done=%b", cyc, s,
             ifc.o_vram_req, ifc.i_vram_ack, ifc.o_vram_addr, ifc.o_done);
  end

  // Reference: address from the row rules with plain arithmetic.
  function automatic int model_addr(int tile, int attr, int y, int sl,
                                    int size, int pt, int plane);
    int row;
    row = ((sl - y + 256) % 256) % 16;
    if (attr >= 128) row = size ? 15 - row : 7 - (row % 8);
    if (size == 0) return pt * 4096 + tile * 16 + plane * 8 + row % 8;
    return (tile % 2) * 4096 + (tile / 2) * 32 + (row / 8) * 16 + plane * 8 + row % 8;
  endfunction

  function automatic void push_ev(int kind, logic [23:0] strb, logic [31:0] val);
    ev_t e;
    e.kind = kind; e.strb = strb; e.val = val;
    q.push_back(e);
  endfunction

  task automatic push_expected(int cnt, int size, int pt, int sl);
    int n, base, a0, a1;
    logic [7:0] oh;
    n = (cnt > 8) ? 8 : cnt;
    base = 0;
    for (int s = 0; s < 8; s++) begin
      oh = 8'd1 << s;
      if (s < n) begin
        a0 = model_addr(soam[s*4+1], soam[s*4+2], soam[s*4], sl, size, pt, 0);
        a1 = model_addr(soam[s*4+1], soam[s*4+2], soam[s*4], sl, size, pt, 1);
        push_ev(0, {oh, 16'd0}, {soam[s*4+2], 24'd0});
        push_ev(0, {8'd0, oh, 8'd0}, {8'd0, soam[s*4+3], 16'd0});
        push_ev(1, 24'd0, 32'(a0));
        push_ev(1, 24'd0, 32'(a1));
        push_ev(0, {16'd0, oh}, {16'd0, vmem[a1], vmem[a0]});
        base += 8;
      end else begin
        push_ev(0, {oh, oh, oh}, {8'h00, 8'hFF, 16'h0000});
        base += 1;
      end
    end
    push_ev(2, 24'd0, 32'(base + 1));
  endtask

  task automatic check_zero(input string nm);
    logic [99:0] o;
    o = {ifc.o_soam_addr, ifc.o_vram_addr, ifc.o_vram_req, ifc.o_xcnt, ifc.o_xcnt_wr,
         ifc.o_attr, ifc.o_attr_we, ifc.o_patt, ifc.o_patt_we, ifc.o_busy, ifc.o_done};
    checks++;
    if (o !== 100'd0) begin
      errors++;
      $display("FAIL %s outputs got %h want 0", nm, o);
    end
  endtask

  task automatic check_bit(input string nm, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, got, want);
    end
  endtask

  task automatic set_slot(int s, int y, int tile, int attr, int x);
    soam[s*4]   = 8'(y);
    soam[s*4+1] = 8'(tile);
    soam[s*4+2] = 8'(attr);
    soam[s*4+3] = 8'(x);
  endtask

  task automatic rand_soam();
    for (int i = 0; i < 32; i++) soam[i] = 8'($urandom);
  endtask

  task automatic run(int cnt, int size, int pt, int sl, int wmode,
                     int busy_at, int abort_at, int start_at_done);
    bit done_seen;
    @(negedge clk);
    wait_mode = wmode;
    cur_wait = pick_wait();
    waits_total = 0;
    fetch_seen = 0;
    ifc.i_spr_cnt = 4'(cnt);
    ifc.i_spr_size = 1'(size);
    ifc.i_spr_pt_sel = 1'(pt);
    ifc.i_scanline = 8'(sl);
    push_expected(cnt, size, pt, sl);
    ifc.i_start = 1'b1;
    @(negedge clk);
    ifc.i_start = 1'b0;
    t1 = cyc;
    check_bit("busy_after_start", ifc.o_busy, 1'b1);
    done_seen = 0;
    for (int k = 1; k < 600 && !done_seen; k++) begin
      @(negedge clk);
      #1;
      if (k == busy_at) ifc.i_start = 1'b1;
      else ifc.i_start = 1'b0;
      if (abort_at >= 0 && fetch_seen == abort_at && ifc.o_vram_req && !ifc.i_vram_ack) begin
        rstn = 1'b0;
        #1;
        check_zero("abort_reset");
        q.delete();
        repeat (3) @(negedge clk);
        check_zero("held_reset");
        rstn = 1'b1;
        return;
      end
      if (ifc.o_done) done_seen = 1;
    end
    if (!done_seen) begin
      errors++;
      $display("FAIL done_timeout got no o_done want o_done within 600 cycles");
      q.delete();
      return;
    end
    if (start_at_done) ifc.i_start = 1'b1;
    @(negedge clk);
    #1;
    ifc.i_start = 1'b0;
    check_bit("idle_after_done", ifc.o_busy, 1'b0);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained got %0d pending want 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
    check_bit("stay_idle", ifc.o_busy, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) vmem[i] = 8'($urandom);
    for (int i = 0; i < 32; i++) soam[i] = 8'd0;
    ifc.i_start = 1'b0;
    ifc.i_scanline = 8'd0;
    ifc.i_spr_cnt = 4'd0;
    ifc.i_spr_size = 1'b0;
    ifc.i_spr_pt_sel = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rstn = 1'b1;

    // Directed: single 8x8 sprite, table 1.
    rand_soam();
    set_slot(0, 16, 8'h42, 8'h01, 100);
    run(1, 0, 1, 20, 0, -1, -1, 0);
    // Directed: V-flipped 8x16 sprite.
    rand_soam();
    set_slot(0, 20, 8'h43, 8'h80, 77);
    run(1, 1, 0, 30, 0, -1, -1, 0);
    // All eight filled, 3 wait cycles per fetch.
    rand_soam();
    run(8, 0, 0, $urandom_range(0, 255), 3, -1, -1, 0);
    // No sprites.
    run(0, 0, 1, 100, 0, -1, -1, 0);
    // Reset during FETCH_HI of slot 3, then a fresh full run.
    rand_soam();
    run(8, 0, 1, $urandom_range(0, 255), 3, -1, 7, 0);
    rand_soam();
    run(8, 1, 0, $urandom_range(0, 255), 0, -1, -1, 0);
    // Start pulsed while busy, and start coinciding with o_done.
    rand_soam();
    run(5, 0, 0, $urandom_range(0, 255), 1, 6, -1, 0);
    rand_soam();
    run(2, 1, 1, $urandom_range(0, 255), 0, -1, -1, 1);
    // Randomized runs, including counts above 8.
    for (int r = 0; r < 12; r++) begin
      rand_soam();
      run($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 255), -1, -1, -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
